// File: rtl/chan_mix.sv
// chan_mix: pairs volume bytes with signed samples, accumulates L/R MACs per frame, emits 16-bit stereo on sync.
// Define MIX_SATURATE_EN to clamp output frames to 16-bit range instead of wrapping.
module chan_mix #(
  parameter int VOL_FIFO_DEPTH = 4,
  parameter int ACC_W = 20,
  parameter int OUT_SHIFT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] in_data,
  input  logic in_stb_mix,
  input  logic [7:0] smp_data,
  input  logic smp_stb,
  input  logic sync_stb,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic out_stb,
  output logic err_vol,
  output logic err_smp
);
  localparam int AW = $clog2(VOL_FIFO_DEPTH);
  localparam logic signed [ACC_W-1:0] MAXV = 32767;
  localparam logic signed [ACC_W-1:0] MINV = -32768;
  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R} state_t;
  state_t r_state;
  logic r_phase;
  logic [5:0] r_vol_hold;
  logic [11:0] r_fifo [VOL_FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic signed [7:0] r_smp;
  logic [5:0] r_vl, r_vr;
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
  logic w_push, w_full, w_empty, w_ins, w_accept, w_pop, w_unused;
  logic signed [13:0] w_a, w_b, w_prod;
  logic signed [ACC_W-1:0] w_add_l, w_add_r;
  assign w_unused = &{1'b0, in_data[7:6]};
  assign w_full = r_cnt == (AW+1)'(VOL_FIFO_DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_push = in_stb_mix && r_phase;
  assign w_ins = w_push && !w_full;
  assign w_accept = smp_stb && r_state != MUL_L;
  assign w_pop = w_accept && !w_empty;
  assign w_a = 14'(r_smp);
  assign w_b = 14'($signed({1'b0, r_state == MUL_L ? r_vl : r_vr}));
  assign w_prod = w_a * w_b;
  assign w_add_l = r_state == MUL_L ? ACC_W'(w_prod) : '0;
  assign w_add_r = r_state == MUL_R ? ACC_W'(w_prod) : '0;
  function automatic logic signed [15:0] conv(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> OUT_SHIFT;
`ifdef MIX_SATURATE_EN
    return s > MAXV ? 16'sh7fff : (s < MINV ? 16'sh8000 : s[15:0]);
`else
    return s[15:0];
`endif
  endfunction
  always_ff @(posedge clk)
    if (w_ins) r_fifo[r_wp] <= {r_vol_hold, in_data[5:0]};
  // A MAC straddling sync puts its L half in the closing frame and its R half in the new one.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_phase <= 1'b0;
      r_vol_hold <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_smp <= '0;
      r_vl <= '0;
      r_vr <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      out_l <= '0;
      out_r <= '0;
      out_stb <= 1'b0;
      err_vol <= 1'b0;
      err_smp <= 1'b0;
    end else begin
      if (in_stb_mix) r_phase <= !r_phase;
      if (in_stb_mix && !r_phase) r_vol_hold <= in_data[5:0];
      if (w_ins) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_ins) - (AW+1)'(w_pop);
      if ((w_push && w_full) || (w_accept && w_empty)) err_vol <= 1'b1;
      if (smp_stb && r_state == MUL_L) err_smp <= 1'b1;
      if (w_pop) {r_smp, r_vl, r_vr} <= {smp_data, r_fifo[r_rp]};
      r_state <= w_pop ? MUL_L : (r_state == MUL_L ? MUL_R : IDLE);
      r_acc_l <= sync_stb ? '0 : r_acc_l + w_add_l;
      r_acc_r <= sync_stb ? w_add_r : r_acc_r + w_add_r;
      out_stb <= sync_stb;
      if (sync_stb) begin
        out_l <= conv(r_acc_l + w_add_l);
        out_r <= conv(r_acc_r);
      end
    end
endmodule

// File: tb/tb_chan_mix.sv
// tb_chan_mix: randomized + directed scoreboard bench for chan_mix against a frame-level reference model.
module tb_chan_mix;
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0, smp_data = 0;
  logic in_stb_mix = 0, smp_stb = 0, sync_stb = 0;
  logic signed [15:0] out_l, out_r;
  logic out_stb, err_vol, err_smp;
  int n_chk = 0, n_pass = 0;
  typedef struct {int l; int r; int ev; int es;} frame_t;
  frame_t exp_q[$];
  int vq[$];
  bit m_phase, m_ev, m_es, m_l_ok, m_r_ok;
  int m_hold, m_l_due, m_r_due, m_r_next;
  longint m_acc_l, m_acc_r;

  always #5 clk = ~clk;

  chan_mix dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_stb_mix(in_stb_mix),
    .smp_data(smp_data), .smp_stb(smp_stb), .sync_stb(sync_stb),
    .out_l(out_l), .out_r(out_r), .out_stb(out_stb),
    .err_vol(err_vol), .err_smp(err_smp)
  );

  task automatic check(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic int conv(longint a);
    longint s;
    s = a >>> 2;
`ifdef MIX_SATURATE_EN
    return s > 32767 ? 32767 : (s < -32768 ? -32768 : int'(s));
`else
    return int'(shortint'(s));
`endif
  endfunction

  task automatic model_reset();
    vq.delete();
    m_phase = 0; m_ev = 0; m_es = 0; m_l_ok = 0; m_r_ok = 0;
    m_hold = 0; m_l_due = 0; m_r_due = 0; m_r_next = 0;
    m_acc_l = 0; m_acc_r = 0;
  endtask

  // One clock of stimulus; the model decides the whole cycle's effect before the edge.
  task automatic cyc(bit ms, int md, bit ss, int sd, bit sy);
    int add_l, add_r, n0, smp, p;
    bit acc;
    in_stb_mix = ms; in_data = 8'(md); smp_stb = ss; smp_data = 8'(sd); sync_stb = sy;
    add_l = m_l_ok ? m_l_due : 0;
    add_r = m_r_ok ? m_r_due : 0;
    n0 = vq.size();
    acc = ss && !m_l_ok;
    if (ss && m_l_ok) m_es = 1;
    if (acc && n0 == 0) m_ev = 1;
    m_r_ok = m_l_ok; m_r_due = m_r_next; m_l_ok = 0;
    if (acc && n0 > 0) begin
      p = vq.pop_front();
      smp = int'(byte'(sd));
      m_l_ok = 1; m_l_due = smp * (p / 64); m_r_next = smp * (p % 64);
    end
    if (ms) begin
      if (!m_phase) m_hold = md & 63;
      else if (n0 == 4) m_ev = 1;
      else vq.push_back(m_hold * 64 + (md & 63));
      m_phase = !m_phase;
    end
    if (sy) begin
      exp_q.push_back('{conv(m_acc_l + add_l), conv(m_acc_r), int'(m_ev), int'(m_es)});
      m_acc_l = 0; m_acc_r = add_r;
    end else begin
      m_acc_l += add_l; m_acc_r += add_r;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic pair(int vl, int vr);
    cyc(1, vl, 0, 0, 0);
    cyc(1, vr, 0, 0, 0);
  endtask

  task automatic do_reset();
    check("pending_before_rst", exp_q.size(), 0);
    exp_q.delete();
    in_stb_mix = 0; smp_stb = 0; sync_stb = 0;
    rst = 1;
    model_reset();
    #2;
    check("rst_out_l", out_l, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_stb", out_stb, 0);
    check("rst_err_vol", err_vol, 0);
    check("rst_err_smp", err_smp, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (!rst && out_stb) begin
      if (exp_q.size() == 0) check("unexpected_out_stb", 1, 0);
      else begin
        f = exp_q.pop_front();
        check("sb_out_l", out_l, f.l);
        check("sb_out_r", out_r, f.r);
        check("sb_err_vol", err_vol, f.ev);
        check("sb_err_smp", err_smp, f.es);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    pair('h3F, 'h20); idle(1);
    cyc(0, 0, 1, 'h40, 0); idle(3);
    cyc(0, 0, 0, 0, 1);
    check("t1_out_l", out_l, 1008);
    check("t1_out_r", out_r, 512);
    idle(5); cyc(0, 0, 0, 0, 1);
    check("t1_empty_l", out_l, 0);
    check("t1_empty_r", out_r, 0);
    for (int i = 0; i < 32; i++) begin pair(63, 63); cyc(0, 0, 1, 'h7F, 0); idle(1); end
    idle(2); cyc(0, 0, 0, 0, 1);
`ifdef MIX_SATURATE_EN
    check("t2_out_l", out_l, 32767);
    check("t2_out_r", out_r, 32767);
`else
    check("t2_out_l", out_l, -1528);
    check("t2_out_r", out_r, -1528);
`endif
    for (int i = 0; i < 32; i++) begin pair(63, 63); cyc(0, 0, 1, 'h80, 0); idle(1); end
    idle(2); cyc(0, 0, 0, 0, 1);
`ifdef MIX_SATURATE_EN
    check("t3_out_l", out_l, -32768);
    check("t3_out_r", out_r, -32768);
`else
    check("t3_out_l", out_l, 1024);
    check("t3_out_r", out_r, 1024);
`endif
    check("t3_err_vol", err_vol, 0);
    check("t3_err_smp", err_smp, 0);
    pair('h10, 'h10); idle(1);
    cyc(0, 0, 1, 'h10, 0); idle(1);
    cyc(0, 0, 0, 0, 1);
    check("t6_out_l", out_l, 64);
    check("t6_out_r", out_r, 0);
    idle(3); cyc(0, 0, 0, 0, 1);
    check("t6_next_l", out_l, 0);
    check("t6_next_r", out_r, 64);
    idle(2);
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(20, 80);
      for (int c = 0; c < len; c++)
        cyc($urandom % 3 == 0, $urandom % 256, $urandom % 4 == 0, $urandom % 256, c == len - 1);
    end
    idle(2);
    do_reset();
    pair(5, 6); pair(7, 8); idle(1);
    cyc(0, 0, 1, 'h11, 0); cyc(0, 0, 1, 'h22, 0);
    check("t5_err_smp", err_smp, 1);
    check("t5_err_vol", err_vol, 0);
    idle(3); cyc(0, 0, 0, 0, 1); idle(2);
    do_reset();
    pair(5, 6); pair(7, 8); idle(1);
    cyc(0, 0, 1, 'h11, 0); idle(1); cyc(0, 0, 1, 'hE2, 0);
    idle(3); cyc(0, 0, 0, 0, 1);
    check("t5b_err_smp", err_smp, 0);
    idle(2);
    do_reset();
    for (int i = 1; i <= 4; i++) pair(i, 10 * i);
    pair(50, 60);
    check("t4_err_vol", err_vol, 1);
    for (int i = 0; i < 4; i++) begin cyc(0, 0, 1, 'h30 + i, 0); idle(1); end
    idle(2); cyc(0, 0, 0, 0, 1);
    check("t4_out_l", out_l, ((48 * 1 + 49 * 2 + 50 * 3 + 51 * 4) >>> 2));
    check("t4_out_r", out_r, ((48 * 10 + 49 * 20 + 50 * 30 + 51 * 40) >>> 2));
    idle(2);
    do_reset();
    pair(40, 40); idle(1);
    cyc(0, 0, 1, 'h50, 0); idle(1);
    do_reset();
    idle(3); cyc(0, 0, 0, 0, 1);
    check("rst_mid_l", out_l, 0);
    check("rst_mid_r", out_r, 0);
    idle(3);
    check("pending_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
